// File: rtl/network_loader.sv
// network_loader: boot sequencer for the multi-CPU network.
// Holds every CPU in reset, streams instruction words from the host into the
// selected CPU's instruction memory (imw strobe, itw data, ima address), then
// releases reset and enables all CPUs together.
module network_loader #(
  parameter int N_CPU     = 9,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 256,
  parameter int RST_CYC   = 4,
  localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              clear_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cpu,
  input  logic [DATA_W-1:0] in_word,
  input  logic              in_last,
  output logic [N_CPU-1:0]  imw,
  output logic [DATA_W-1:0] itw,
  output logic [AW-1:0]     ima,
  output logic [N_CPU-1:0]  cpu_rst,
  output logic [N_CPU-1:0]  cpu_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int HW = $clog2(RST_CYC + 1);

  localparam logic [CW-1:0] MAXC      = CW'(MAX_WORDS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYC - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HOLD    = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_RUN     = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  logic [2:0]       state;
  logic [HW-1:0]    hold_cnt;
  logic [CW-1:0]    cnt [N_CPU];
  logic [N_CPU-1:0] sel_hit;
  logic [CW-1:0]    sel_cnt;
  logic             sel_ok;
  logic             sel_full;

  // Decode the target CPU and fetch its word counter; out-of-range indices hit nothing.
  always_comb begin
    sel_hit = '0;
    sel_cnt = '0;
    for (int unsigned i = 0; i < N_CPU; i++) begin
      if (in_cpu == 4'(i)) begin
        sel_hit[i] = 1'b1;
        sel_cnt    = cnt[i];
      end
    end
  end

  assign sel_ok   = |sel_hit;
  assign sel_full = (sel_cnt == MAXC);

  // State-derived control outputs.
  always_comb begin
    in_ready = (state == S_LOAD);
    busy     = (state == S_HOLD) || (state == S_LOAD) ||
               (state == S_DRAIN) || (state == S_RELEASE);
    done     = (state == S_RUN);
    err      = (state == S_ERR);
    cpu_en   = {N_CPU{state == S_RUN}};
    cpu_rst  = {N_CPU{!((state == S_RELEASE) || (state == S_RUN))}};
  end

  // Sequencer FSM, write pipeline and per-CPU word counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      imw          <= '0;
      itw          <= '0;
      ima          <= '0;
      words_loaded <= '0;
      for (int unsigned i = 0; i < N_CPU; i++) cnt[i] <= '0;
    end else begin
      imw <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_HOLD;
            hold_cnt     <= '0;
            words_loaded <= '0;
            for (int unsigned i = 0; i < N_CPU; i++) cnt[i] <= '0;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) state <= S_LOAD;
          else hold_cnt <= hold_cnt + 1'b1;
        end
        S_LOAD: begin
          if (in_valid) begin
            // Error check outranks in_last: a bad final word is dropped, not written.
            if (!sel_ok || sel_full) begin
              state <= S_ERR;
            end else begin
              imw          <= sel_hit;
              itw          <= in_word;
              ima          <= sel_cnt[AW-1:0];
              words_loaded <= words_loaded + 16'd1;
              for (int unsigned i = 0; i < N_CPU; i++)
                if (sel_hit[i]) cnt[i] <= cnt[i] + 1'b1;
              if (in_last) state <= S_DRAIN;
            end
          end
        end
        S_DRAIN:   state <= S_RELEASE;
        S_RELEASE: state <= S_RUN;
        S_RUN:     if (halt) state <= S_IDLE;
        S_ERR:     if (clear_err) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_network_loader.sv
// Directed self-checking bench for network_loader (default parameters).
module tb_network_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt;
  logic        clear_err;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cpu;
  logic [31:0] in_word;
  logic        in_last;
  logic [8:0]  imw;
  logic [31:0] itw;
  logic [7:0]  ima;
  logic [8:0]  cpu_rst;
  logic [8:0]  cpu_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int checks;
  int failures;

  network_loader #(
    .N_CPU(9), .DATA_W(32), .MAX_WORDS(256), .RST_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clear_err(clear_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_cpu(in_cpu),
    .in_word(in_word), .in_last(in_last), .imw(imw), .itw(itw), .ima(ima),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] w, input logic l);
    in_valid = v;
    in_cpu   = c;
    in_word  = w;
    in_last  = l;
  endtask

  // IDLE -> HOLD, checking HOLD spans exactly four cycles, ends in LOAD.
  task automatic boot_to_load(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_busy"}, busy, 1);
      tick();
    end
    chk({tag, "_load_ready"}, in_ready, 1);
    chk({tag, "_load_rst"}, cpu_rst, 9'h1FF);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; start = 1'b0; halt = 1'b0; clear_err = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_rst", cpu_rst, 9'h1FF);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_imw", imw, 0);
    chk("rst_itw", itw, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_flags", {busy, done, err}, 3'b000);
    chk("rst_words", words_loaded, 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Basic boot: two words, CPU0 then CPU8 (last).
    boot_to_load("basic");
    drive(1'b1, 4'd0, 32'hA000_0001, 1'b0);
    tick();
    chk("basic_imw0", imw, 9'h001);
    chk("basic_itw0", itw, 32'hA000_0001);
    chk("basic_ima0", ima, 0);
    chk("basic_words1", words_loaded, 1);
    drive(1'b1, 4'd8, 32'hB000_0002, 1'b1);
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0);
    chk("basic_imw1", imw, 9'h100);
    chk("basic_itw1", itw, 32'hB000_0002);
    chk("drain_ready", in_ready, 0);
    chk("drain_rst", cpu_rst, 9'h1FF);
    chk("drain_busy", busy, 1);
    tick();
    chk("rel_imw", imw, 0);
    chk("rel_itw_hold", itw, 32'hB000_0002);
    chk("rel_rst", cpu_rst, 0);
    chk("rel_en", cpu_en, 0);
    chk("rel_busy", busy, 1);
    tick();
    chk("run_en", cpu_en, 9'h1FF);
    chk("run_rst", cpu_rst, 0);
    chk("run_done", done, 1);
    chk("run_busy", busy, 0);
    chk("run_words", words_loaded, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_start_ignored", done, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_en", cpu_en, 0);
    chk("halt_rst", cpu_rst, 9'h1FF);
    chk("halt_done", done, 0);
    chk("halt_idle_busy", busy, 0);

    // Streaming: ten back-to-back beats to CPU3, plus a last one.
    boot_to_load("stream");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_start_ignored", in_ready, 1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 4'd3, 32'h3000_0000 + k, 1'b0);
      tick();
      chk("stream_imw", imw, 9'h008);
      chk("stream_itw", itw, 32'h3000_0000 + k);
      chk("stream_ima", ima, k);
      chk("stream_words", words_loaded, k + 1);
    end
    drive(1'b1, 4'd3, 32'h3000_00FF, 1'b1);
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0);
    chk("stream_cnt10", ima, 10);
    chk("stream_last_imw", imw, 9'h008);
    chk("stream_words11", words_loaded, 11);
    tick();
    tick();
    chk("stream_run", done, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;

    // Bad index: CPU 9 does not exist.
    boot_to_load("badidx");
    drive(1'b1, 4'd9, 32'hDEAD_BEEF, 1'b0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0);
    chk("bad_imw", imw, 0);
    chk("bad_itw_hold", itw, 32'h3000_00FF);
    chk("bad_err", err, 1);
    chk("bad_rst", cpu_rst, 9'h1FF);
    chk("bad_en", cpu_en, 0);
    chk("bad_ready", in_ready, 0);
    chk("bad_words", words_loaded, 0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("err_halt_ignored", err, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_busy", busy, 0);

    // Overflow: 256 words fill CPU1, the 257th is rejected.
    boot_to_load("ovf");
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 4'd1, 32'h1000_0000 + k, 1'b0);
      tick();
    end
    chk("ovf_imw255", imw, 9'h002);
    chk("ovf_ima255", ima, 255);
    chk("ovf_words256", words_loaded, 256);
    drive(1'b1, 4'd1, 32'h1FFF_FFFF, 1'b1);
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0);
    chk("ovf_imw", imw, 0);
    chk("ovf_err", err, 1);
    chk("ovf_words", words_loaded, 256);
    chk("ovf_itw_hold", itw, 32'h1000_00FF);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;

    // Abort: reset lands while a write strobe is high.
    boot_to_load("abort");
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'd2, 32'h2000_0000 + k, 1'b0);
      tick();
    end
    drive(1'b0, 4'd0, 32'h0, 1'b0);
    chk("abort_pre_imw", imw, 9'h004);
    chk("abort_pre_words", words_loaded, 5);
    #2 rst = 1'b0;
    #1;
    chk("abort_imw", imw, 0);
    chk("abort_rst", cpu_rst, 9'h1FF);
    chk("abort_ready", in_ready, 0);
    chk("abort_words", words_loaded, 0);
    #1 rst = 1'b1;
    tick();
    boot_to_load("reload");
    drive(1'b1, 4'd2, 32'h2222_0000, 1'b0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 1'b0);
    chk("reload_words", words_loaded, 1);
    chk("reload_ima", ima, 0);
    chk("reload_imw", imw, 9'h004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
